// File: rtl/cam_init_pkg.sv
// Shared types and constants for the OV5640 init-table sequencer.
// Entry layout in the table BRAM: {reg_addr[15:0], data[7:0]}.
package cam_init_pkg;

  typedef struct packed {
    logic [15:0] reg_addr;
    logic [7:0]  data;
  } init_entry_t;

  localparam logic [23:0] END_ENTRY = 24'h000000;
  localparam logic [15:0] DELAY_REG = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_RD,
    S_DECODE,
    S_ISSUE,
    S_WAIT_RSP,
    S_DELAY,
    S_DONE
  } seq_state_t;

  typedef enum logic [1:0] {
    ENT_WRITE,
    ENT_DELAY,
    ENT_END
  } entry_kind_t;

  function automatic entry_kind_t classify(input init_entry_t e);
    if (e == init_entry_t'(END_ENTRY)) return ENT_END;
    if (e.reg_addr == DELAY_REG)       return ENT_DELAY;
    return ENT_WRITE;
  endfunction

endpackage

// File: rtl/ms_delay_timer.sv
// Millisecond delay timer: load a ms count, expire pulses in the last cycle of
// ms*CYCLES_PER_MS cycles. Counter is sized so 255 ms never overflows.
module ms_delay_timer
  import cam_init_pkg::*;
#(
  parameter int CYCLES_PER_MS = 100_000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       load,
  input  logic [7:0] ms,
  output logic       expire
);

  localparam int CNT_W = $clog2(255 * CYCLES_PER_MS + 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(ms) * CNT_W'(CYCLES_PER_MS);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expire = (cnt == CNT_W'(1));

endmodule

// File: rtl/cam_init_sequencer.sv
// Walks the camera init table and issues one SCCB register write per entry.
// Optional feature macro: CAM_INIT_RETRY_EN (reissue NACKed entries up to MAX_RETRIES).
module cam_init_sequencer
  import cam_init_pkg::*;
#(
  parameter int ADDR_W        = 9,
  parameter int CYCLES_PER_MS = 100_000
`ifdef CAM_INIT_RETRY_EN
  , parameter int MAX_RETRIES = 3
`endif
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_valid,
  output logic              start_ready,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [23:0]       bram_dout,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [15:0]       wr_reg_addr,
  output logic [7:0]        wr_data,
  input  logic              rsp_valid,
  input  logic              rsp_nack,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_index
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  seq_state_t        state;
  logic [ADDR_W-1:0] idx;
  init_entry_t       entry;
  entry_kind_t       kind;
  logic              timer_load;
  logic              timer_expire;
  logic              advance;
  logic              retry_ok;

  assign entry       = init_entry_t'(bram_dout);
  assign kind        = classify(entry);
  assign start_ready = (state == S_IDLE);
  assign timer_load  = (state == S_DECODE) && (kind == ENT_DELAY);

  ms_delay_timer #(.CYCLES_PER_MS(CYCLES_PER_MS)) u_timer (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .load   (timer_load),
    .ms     (entry.data),
    .expire (timer_expire)
  );

`ifdef CAM_INIT_RETRY_EN
  localparam int RETRY_W = $clog2(MAX_RETRIES + 2);

  logic [RETRY_W-1:0] retry_cnt;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      retry_cnt <= '0;
    end else if (state == S_DECODE) begin
      retry_cnt <= '0;
    end else if (state == S_WAIT_RSP && rsp_valid && rsp_nack && retry_ok) begin
      retry_cnt <= retry_cnt + RETRY_W'(1);
    end
  end

  assign retry_ok = (retry_cnt < RETRY_W'(MAX_RETRIES));
`else
  assign retry_ok = 1'b0;
`endif

  // Entry finished successfully: ACKed write, zero delay, or expired delay.
  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    advance = 1'b0;
    case (state)
      S_WAIT_RSP: advance = rsp_valid && !rsp_nack;
      S_DECODE:   advance = (kind == ENT_DELAY) && (entry.data == 8'd0);
      S_DELAY:    advance = timer_expire;
      default:    advance = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state       <= S_IDLE;
      idx         <= '0;
      bram_addr   <= '0;
      wr_valid    <= 1'b0;
      wr_reg_addr <= '0;
      wr_data     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_index   <= '0;
    end else begin
      done <= 1'b0;
      if (advance) begin
        // The last table slot ends the run like END; the index never wraps.
        if (idx == LAST_IDX) begin
          state <= S_DONE;
          done  <= 1'b1;
        end else begin
          idx       <= idx + ADDR_W'(1);
          bram_addr <= idx + ADDR_W'(1);
          state     <= S_FETCH;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (start_valid) begin
              idx       <= '0;
              bram_addr <= '0;
              busy      <= 1'b1;
              error     <= 1'b0;
              state     <= S_FETCH;
            end
          end
          S_FETCH:   state <= S_WAIT_RD;
          S_WAIT_RD: state <= S_DECODE;
          S_DECODE: begin
            case (kind)
              ENT_END: begin
                done  <= 1'b1;
                state <= S_DONE;
              end
              ENT_DELAY: state <= S_DELAY;
              default: begin
                wr_reg_addr <= entry.reg_addr;
                wr_data     <= entry.data;
                wr_valid    <= 1'b1;
                state       <= S_ISSUE;
              end
            endcase
          end
          S_ISSUE: begin
            if (wr_ready) begin
              wr_valid <= 1'b0;
              state    <= S_WAIT_RSP;
            end
          end
          S_WAIT_RSP: begin
            // An ACK is taken by the advance path, so a response here is a NACK.
            if (rsp_valid) begin
              if (retry_ok) begin
                wr_valid <= 1'b1;
                state    <= S_ISSUE;
              end else begin
                error     <= 1'b1;
                err_index <= idx;
                busy      <= 1'b0;
                state     <= S_IDLE;
              end
            end
          end
          S_DELAY: state <= S_DELAY;
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
